voiceprint_matcher: RTL

Consumes the 13-coefficient MFCC frame stream produced by `feature_extractor` and averages NUM_FRAMES consecutive frames into a mean feature vector. In enroll mode it stores that mean as the speaker template. In verify mode it computes the squared Euclidean distance between the mean and the stored template, then reports a match/no-match decision against a runtime threshold. It is the final stage of the biometrics pipeline.

---
 rtl/biometrics_pkg.sv | 23 ++
 rtl/sq_dist_accum.sv | 43 ++++
 rtl/voiceprint_matcher.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/biometrics_pkg.sv
// Shared constants, FSM state type and saturating arithmetic for the
// biometrics pipeline (feature_extractor -> voiceprint_matcher).
package biometrics_pkg;

    localparam int NUM_FEATURES = 13;
    localparam int FEATURE_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DIST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Unsigned add clamped to 32 bits; once at the ceiling it stays there
    // because the addend is never negative.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {33'd0, a} + {1'b0, b};
        return (s > 65'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/sq_dist_accum.sv
// Running saturated sum of (mean - template)^2, one coefficient pair per cycle.
// sum_next_out is the value the register takes at the coming edge.
module sq_dist_accum
    import biometrics_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                clear_in,
    input  logic                valid_in,
    input  logic signed [W-1:0] mean_in,
    input  logic signed [W-1:0] template_in,
    output logic [31:0]         sum_out,
    output logic [31:0]         sum_next_out
);

    logic signed [W:0]       w_diff;
    logic signed [2*W+1:0]   w_diff_x;
    logic [2*W+1:0]          w_sq;
    logic [31:0]             r_sum;

    always_comb begin
        w_diff   = {mean_in[W-1], mean_in} - {template_in[W-1], template_in};
        w_diff_x = {{(W+1){w_diff[W]}}, w_diff};
        w_sq     = w_diff_x * w_diff_x;
        sum_next_out = r_sum;
        if (clear_in)
            sum_next_out = 32'd0;
        else if (valid_in)
            sum_next_out = sat_add(r_sum, {{(64-2*W-2){1'b0}}, w_sq});
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_sum <= 32'd0;
        else
            r_sum <= sum_next_out;
    end

    assign sum_out = r_sum;

endmodule

// File: rtl/voiceprint_matcher.sv
// Averages NUM_FRAMES MFCC frames; enroll stores the mean as a template,
// verify reports the saturated squared distance and a threshold decision.
module voiceprint_matcher
    import biometrics_pkg::*;
#(
    parameter int NUM_FEATURES = biometrics_pkg::NUM_FEATURES,
    parameter int NUM_FRAMES   = 16,
    parameter int FEATURE_W    = biometrics_pkg::FEATURE_W
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [FEATURE_W-1:0] feature_data_in,
    input  logic                 feature_valid_in,
    input  logic                 feature_last_in,
    output logic                 feature_ready_out,
    input  logic                 start_in,
    input  logic                 enroll_in,
    input  logic [31:0]          threshold_in,
    output logic                 busy_out,
    output logic                 template_valid_out,
    output logic                 result_valid_out,
    output logic                 match_out,
    output logic [31:0]          distance_out,
    output logic [1:0]           state_dbg_out
);

    localparam int SH    = $clog2(NUM_FRAMES);
    localparam int ACC_W = FEATURE_W + SH;
    localparam int IDX_W = $clog2(NUM_FEATURES + 1);
    localparam int K_W   = $clog2(NUM_FEATURES);
    localparam int FRM_W = SH;

    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_FEATURES);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(NUM_FEATURES - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(NUM_FRAMES - 1);

    state_t r_state, w_state_next;

    logic signed [ACC_W-1:0]     r_acc  [NUM_FEATURES];
    logic signed [FEATURE_W-1:0] r_tmpl [NUM_FEATURES];
    logic [IDX_W-1:0]            r_idx;
    logic [FRM_W-1:0]            r_frame_cnt;
    logic [K_W-1:0]              r_k;
    logic                        r_enroll;
    logic [31:0]                 r_thresh;
    logic                        r_tmpl_valid;
    logic                        r_match;
    logic [31:0]                 r_distance;

    logic                        w_accept;
    logic                        w_final;
    logic signed [ACC_W-1:0]     w_data_ext;
    logic signed [ACC_W-1:0]     w_acc_next   [NUM_FEATURES];
    logic signed [ACC_W-1:0]     w_shift_next [NUM_FEATURES];
    logic signed [FEATURE_W-1:0] w_mean_next  [NUM_FEATURES];
    logic signed [ACC_W-1:0]     w_shift_k;
    logic signed [FEATURE_W-1:0] w_mean_k;
    logic                        w_clear;
    logic                        w_dist_valid;
    logic [31:0]                 w_sum;
    logic [31:0]                 w_sum_next;

    assign w_accept   = (r_state == ACCUM) && feature_valid_in;
    assign w_final    = w_accept && feature_last_in && (r_frame_cnt == FRM_LAST);
    assign w_data_ext = {{SH{feature_data_in[FEATURE_W-1]}}, feature_data_in};

    // Accumulators including the beat accepted this cycle, so the template
    // can be captured on the same edge as the final beat.
    always_comb begin
        for (int k = 0; k < NUM_FEATURES; k++) begin
            w_acc_next[k] = r_acc[k];
            if (w_accept && (r_idx == IDX_W'(k)))
                w_acc_next[k] = r_acc[k] + w_data_ext;
            w_shift_next[k] = w_acc_next[k] >>> SH;
            w_mean_next[k]  = w_shift_next[k][FEATURE_W-1:0];
        end
    end

    assign w_shift_k    = r_acc[r_k] >>> SH;
    assign w_mean_k     = w_shift_k[FEATURE_W-1:0];
    assign w_clear      = (r_state == IDLE) && start_in;
    assign w_dist_valid = (r_state == DIST);

    sq_dist_accum #(
        .W (FEATURE_W)
    ) u_sq_dist_accum (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .clear_in     (w_clear),
        .valid_in     (w_dist_valid),
        .mean_in      (w_mean_k),
        .template_in  (r_tmpl[r_k]),
        .sum_out      (w_sum),
        .sum_next_out (w_sum_next)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (start_in) w_state_next = ACCUM;
            ACCUM: begin
                if (w_final) begin
                    if (!r_enroll && r_tmpl_valid)
                        w_state_next = DIST;
                    else
                        w_state_next = DONE;
                end
            end
            DIST:  if (r_k == K_LAST) w_state_next = DONE;
            DONE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < NUM_FEATURES; k++) begin
                r_acc[k]  <= '0;
                r_tmpl[k] <= '0;
            end
            r_idx        <= '0;
            r_frame_cnt  <= '0;
            r_k          <= '0;
            r_enroll     <= 1'b0;
            r_thresh     <= 32'd0;
            r_tmpl_valid <= 1'b0;
            r_match      <= 1'b0;
            r_distance   <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_enroll    <= enroll_in;
                        r_thresh    <= threshold_in;
                        r_idx       <= '0;
                        r_frame_cnt <= '0;
                        r_k         <= '0;
                        for (int k = 0; k < NUM_FEATURES; k++)
                            r_acc[k] <= '0;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        for (int k = 0; k < NUM_FEATURES; k++)
                            r_acc[k] <= w_acc_next[k];
                        if (feature_last_in) begin
                            r_idx       <= '0;
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end else if (r_idx < IDX_MAX) begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    if (w_final) begin
                        r_k <= '0;
                        if (r_enroll) begin
                            for (int k = 0; k < NUM_FEATURES; k++)
                                r_tmpl[k] <= w_mean_next[k];
                            r_tmpl_valid <= 1'b1;
                            r_match      <= 1'b0;
                            r_distance   <= 32'd0;
                        end else if (!r_tmpl_valid) begin
                            r_match    <= 1'b0;
                            r_distance <= 32'hFFFF_FFFF;
                        end
                    end
                end
                DIST: begin
                    r_k <= r_k + 1'b1;
                    // Capture the sum that includes the last coefficient so the
                    // result is visible in the DONE cycle itself.
                    if (r_k == K_LAST) begin
                        r_distance <= w_sum_next;
                        r_match    <= (w_sum_next <= r_thresh);
                    end
                end
                default: ;
            endcase
        end
    end

    assign feature_ready_out  = (r_state == ACCUM);
    assign busy_out           = (r_state != IDLE);
    assign result_valid_out   = (r_state == DONE);
    assign template_valid_out = r_tmpl_valid;
    assign match_out          = r_match;
    assign distance_out       = r_distance;
    assign state_dbg_out      = r_state;

endmodule
